// File: rtl/pc060ha_mailbox_ctrl.sv
// Two-sided nibble mailbox between a master CPU and a sound CPU.
// Each side has a page pointer, a TX mailbox it fills and an RX mailbox it drains.
module pc060ha_mailbox_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic       CLK,
  input  logic       nRESET,
  input  logic       M_nCS,
  input  logic       M_nRD,
  input  logic       M_nWR,
  input  logic       M_A0,
  input  logic [3:0] M_DIN,
  output logic [3:0] M_DOUT,
  input  logic       S_nCS,
  input  logic       S_nRD,
  input  logic       S_nWR,
  input  logic       S_A0,
  input  logic [3:0] S_DIN,
  output logic [3:0] S_DOUT,
  output logic       S_nNMI,
  output logic       S_RESET_OUT
);
  localparam logic [2:0] LAST = 3'(NIBBLES - 1);

  logic [3:0] m2s_mb [NIBBLES];
  logic [3:0] s2m_mb [NIBBLES];
  logic       m2s_full, s2m_full, nmi_en;

  logic       m_rd_act, m_wr_act, m_rd_q, m_wr_q, m_a0_q;
  logic       s_rd_act, s_wr_act, s_rd_q, s_wr_q, s_a0_q;
  logic [3:0] m_din_q, s_din_q, m_rx_data, s_rx_data;
  logic [2:0] m_ptr, s_ptr;
  logic       m_rd_start, m_wr_start, m_rd_commit, m_wr_commit;
  logic       s_rd_start, s_wr_start, s_rd_commit, s_wr_commit;
  logic       m_data_commit, m_tx_write, m_ctl_write;
  logic       s_data_commit, s_tx_write, s_ctl_write;
  logic       m2s_set, m2s_clr, s2m_set, s2m_clr;

  function automatic logic [2:0] next_ptr(input logic [2:0] p);
    return (p >= LAST) ? 3'd0 : p + 3'd1;
  endfunction

  // A read strobe overlapping a write strobe is dropped in favour of the write.
  assign m_wr_act = ~M_nCS & ~M_nWR;
  assign m_rd_act = ~M_nCS & ~M_nRD & M_nWR;
  assign s_wr_act = ~S_nCS & ~S_nWR;
  assign s_rd_act = ~S_nCS & ~S_nRD & S_nWR;

  assign m_rd_start  = m_rd_act & ~m_rd_q;
  assign m_wr_start  = m_wr_act & ~m_wr_q;
  assign m_rd_commit = m_rd_q & ~m_rd_act;
  assign m_wr_commit = m_wr_q & ~m_wr_act;
  assign s_rd_start  = s_rd_act & ~s_rd_q;
  assign s_wr_start  = s_wr_act & ~s_wr_q;
  assign s_rd_commit = s_rd_q & ~s_rd_act;
  assign s_wr_commit = s_wr_q & ~s_wr_act;

  assign m_data_commit = (m_rd_commit | m_wr_commit) & m_a0_q;
  assign m_tx_write    = m_wr_commit & m_a0_q;
  assign m_ctl_write   = m_wr_commit & ~m_a0_q;
  assign s_data_commit = (s_rd_commit | s_wr_commit) & s_a0_q;
  assign s_tx_write    = s_wr_commit & s_a0_q;
  assign s_ctl_write   = s_wr_commit & ~s_a0_q;

  assign m2s_set = m_tx_write & (m_ptr == LAST);
  assign m2s_clr = s_rd_commit & s_a0_q & (s_ptr == LAST);
  assign s2m_set = s_tx_write & (s_ptr == LAST);
  assign s2m_clr = m_rd_commit & m_a0_q & (m_ptr == LAST);

  // Out-of-range pointers match no entry and read back as zero.
  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    m_rx_data = '0;
    s_rx_data = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (m_ptr == 3'(i)) m_rx_data = s2m_mb[i];
      if (s_ptr == 3'(i)) s_rx_data = m2s_mb[i];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      m_rd_q      <= 1'b0;
      m_wr_q      <= 1'b0;
      m_a0_q      <= 1'b0;
      m_din_q     <= '0;
      m_ptr       <= '0;
      M_DOUT      <= '0;
      S_RESET_OUT <= 1'b0;
    end else begin
      m_rd_q <= m_rd_act;
      m_wr_q <= m_wr_act;
      if (m_rd_start || m_wr_start) m_a0_q <= M_A0;
      if (m_wr_start) m_din_q <= M_DIN;
      if (m_rd_start) M_DOUT <= M_A0 ? m_rx_data : {2'b00, s2m_full, m2s_full};
      if (m_ctl_write) begin
        if (m_din_q[3]) S_RESET_OUT <= m_din_q[0];
        else            m_ptr       <= m_din_q[2:0];
      end else if (m_data_commit) begin
        m_ptr <= next_ptr(m_ptr);
      end
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      s_rd_q  <= 1'b0;
      s_wr_q  <= 1'b0;
      s_a0_q  <= 1'b0;
      s_din_q <= '0;
      s_ptr   <= '0;
      S_DOUT  <= '0;
      nmi_en  <= 1'b0;
    end else begin
      s_rd_q <= s_rd_act;
      s_wr_q <= s_wr_act;
      if (s_rd_start || s_wr_start) s_a0_q <= S_A0;
      if (s_wr_start) s_din_q <= S_DIN;
      if (s_rd_start) S_DOUT <= S_A0 ? s_rx_data : {2'b00, m2s_full, s2m_full};
      if (s_ctl_write) begin
        if (s_din_q[3]) nmi_en <= s_din_q[0];
        else            s_ptr  <= s_din_q[2:0];
      end else if (s_data_commit) begin
        s_ptr <= next_ptr(s_ptr);
      end
    end
  end

  // NOTE: the mailbox arrays sit under reset because a read after reset must return 0.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      for (int i = 0; i < NIBBLES; i++) begin
        m2s_mb[i] <= '0;
        s2m_mb[i] <= '0;
      end
      m2s_full <= 1'b0;
      s2m_full <= 1'b0;
      S_nNMI   <= 1'b1;
    end else begin
      for (int i = 0; i < NIBBLES; i++) begin
        if (m_tx_write && m_ptr == 3'(i)) m2s_mb[i] <= m_din_q;
        if (s_tx_write && s_ptr == 3'(i)) s2m_mb[i] <= s_din_q;
      end
      // A same-cycle set beats the clear.
      m2s_full <= m2s_set | (m2s_full & ~m2s_clr);
      s2m_full <= s2m_set | (s2m_full & ~s2m_clr);
      S_nNMI   <= ~(m2s_full & nmi_en);
    end
  end

endmodule

// File: doc/pc060ha_mailbox_ctrl.md
Name: pc060ha_mailbox_ctrl

Overview:
Two-sided nibble mailbox controller for the sound-communication interface between the main (master) CPU and the sound (slave) CPU. Each side has a 3-bit page pointer with auto-increment, a private TX mailbox it writes and an RX mailbox it reads, plus full flags. The block arbitrates simultaneous flag set/clear between the two sides and raises the slave NMI when a complete master message is waiting. Fully synchronous to CLK. Both CPU buses are sampled on CLK.

Parameters:
NIBBLES, 4, nibble registers per direction; legal range 1..8.

Ports:
CLK  in  1  system clock
nRESET  in  1  asynchronous active-low reset
M_nCS  in  1  master chip select, active low
M_nRD  in  1  master read strobe, active low
M_nWR  in  1  master write strobe, active low
M_A0  in  1  master mode select: 0 = pointer/status, 1 = data
M_DIN  in  4  master write data
M_DOUT  out  4  master read data
S_nCS, S_nRD, S_nWR, S_A0, S_DIN[3:0], S_DOUT[3:0]  as master, for slave
S_nNMI  out  1  slave NMI request, active low
S_RESET_OUT  out  1  slave CPU reset request, active high

Behaviour:
- Reset (async, nRESET low): both pointers = 0, all mailbox nibbles = 0, m2s_full = s2m_full = 0, nmi_en = 0, S_RESET_OUT = 0, M_DOUT = S_DOUT = 0. S_nNMI = 1. Reset mid-access aborts the access with no side effects.
- Strobe detection, per side, on posedge CLK: rd_act = ~nCS & ~nRD and wr_act = ~nCS & ~nWR, each registered. An access is "committed" on the first cycle where the registered act = 1 and the current act = 0 (end of strobe). Each strobe produces exactly one commit. A0 and DIN are latched on the first cycle of the strobe. Commit uses the latched values.
- Read data: on the first cycle of rd_act, DOUT is loaded with the addressed value and is held until the next read start. Read latency is 1 CLK from strobe assertion. A0=0 read returns {2'b00, rx_full, tx_full} from that side's point of view. A0=1 read returns rx_mailbox[ptr], or 0 if ptr >= NIBBLES.
- Write A0=0, DIN[3]=0: ptr <= DIN[2:0].
- Write A0=0, DIN[3]=1, master side: S_RESET_OUT <= DIN[0]. Pointer is unchanged.
- Write A0=0, DIN[3]=1, slave side: nmi_en <= DIN[0]. Pointer is unchanged.
- Write A0=1: tx_mailbox[ptr] <= DIN. Ignored if ptr >= NIBBLES.
- Pointer advance: every A0=1 commit (read or write) advances ptr. If ptr >= NIBBLES-1, ptr <= 0; otherwise ptr <= ptr+1. Out-of-range pointers therefore wrap to 0.
- Flags: m2s_full is set on a master A0=1 write commit at ptr == NIBBLES-1. It is cleared on a slave A0=1 read commit at ptr == NIBBLES-1. s2m_full is symmetric, with the slave writing and the master reading.
- Simultaneous set and clear of the same flag in one cycle: set wins, and the flag stays 1.
- A write to the mailbox entry the other side is reading in the same cycle: the reader gets the pre-write value, because DOUT was latched at strobe start.
- Writes while tx_full = 1 are accepted and overwrite the entry. The flag is unchanged except by the last-index rule.
- S_nNMI = ~(m2s_full & nmi_en). It is registered, so it follows the flag 1 CLK later.
- The master and slave sides are fully independent apart from the shared flags and mailboxes. Concurrent commits on both sides in one cycle are both honoured.
- Strobes with nCS high are ignored. If nRD and nWR are both low, write takes priority and the read is dropped.

Test Plan:
- Reset then master status read -> M_DOUT = 4'h0; S_nNMI = 1; S_RESET_OUT = 0.
- Master writes pointer 0, then data 1,2,3,4; slave writes A0=0 DIN=4'h9 -> m2s_full = 1 after the 4th commit; S_nNMI = 0 one CLK later; master status read = 4'h1.
- Slave writes pointer 0 and reads A0=1 four times -> S_DOUT = 1,2,3,4; m2s_full clears after the 4th commit; S_nNMI returns to 1; slave pointer wraps to 0.
- Set and clear in the same CLK: master's last-nibble write commit coincides with slave's last-nibble read commit -> m2s_full = 1 afterwards.
- Master pointer write 4'h6 with NIBBLES = 4, then data read -> M_DOUT = 0; the next pointer value is 0; no flag changes.
- Assert nRESET low mid-strobe (during master write) -> all outputs return to reset values immediately; no commit on release.
